regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass.sv | 108 ++++++++++
 tb/tb_regfile_bypass.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with same-cycle write bypass, per-byte write
// enables and a pending (scoreboard) bit per register with a registered pending count.
module regfile_bypass #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_1,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_2,
    output logic [DATA_WIDTH-1:0]   rd_data_1,
    output logic [DATA_WIDTH-1:0]   rd_data_2,
    output logic                    rd_pend_1,
    output logic                    rd_pend_2,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
    input  logic                    rsv_en,
    input  logic [ADDR_WIDTH-1:0]   rsv_addr,
    output logic [ADDR_WIDTH:0]     pend_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;
    logic [CNT_W-1:0]      pend_count_q;
    logic [CNT_W-1:0]      pend_count_d;

    logic                  wr_ok;
    logic                  rsv_ok;
    logic [DATA_WIDTH-1:0] wr_merged;

    // Address 0 is inert only when it is configured as the hardwired-zero register.
    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Qualified strobes and the byte-merged write value (also the bypass value).
    always_comb begin
        wr_ok     = wr_en && !is_zero(wr_addr);
        rsv_ok    = rsv_en && !is_zero(rsv_addr);
        wr_merged = regs_q[wr_addr];
        for (int unsigned b = 0; b < NB; b++) begin
            if (wr_byte_en[b]) begin
                wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Next state: write clears pending, a same-address reservation then sets it again.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_merged;
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
        pend_count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_count_d = pend_count_d + CNT_W'(pend_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q       <= '0;
            pend_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
        end
    end

    // Zero-latency read ports; a forwarded write hides the pending bit unless re-reserved.
    always_comb begin
        rd_data_1 = '0;
        rd_data_2 = '0;
        rd_pend_1 = 1'b0;
        rd_pend_2 = 1'b0;
        if (!reset && !is_zero(rd_addr_1)) begin
            rd_data_1 = (wr_ok && wr_addr == rd_addr_1) ? wr_merged : regs_q[rd_addr_1];
            rd_pend_1 = (wr_ok && wr_addr == rd_addr_1 && !(rsv_ok && rsv_addr == rd_addr_1))
                        ? 1'b0 : pend_q[rd_addr_1];
        end
        if (!reset && !is_zero(rd_addr_2)) begin
            rd_data_2 = (wr_ok && wr_addr == rd_addr_2) ? wr_merged : regs_q[rd_addr_2];
            rd_pend_2 = (wr_ok && wr_addr == rd_addr_2 && !(rsv_ok && rsv_addr == rd_addr_2))
                        ? 1'b0 : pend_q[rd_addr_2];
        end
    end

    assign pend_count = pend_count_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed, table-driven bench for regfile_bypass (32-bit data, 32 entries, x0 hardwired).
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_1, rd_addr_2;
    logic [31:0] rd_data_1, rd_data_2;
    logic        rd_pend_1, rd_pend_2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [5:0]  pend_count;

    int checks = 0;
    int errors = 0;

    regfile_bypass #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .rd_pend_1(rd_pend_1), .rd_pend_2(rd_pend_2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        p1;
        logic        p2;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [4:0] ra,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic p1, input logic p2, input logic [5:0] cnt);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra;
        v.a1 = a1; v.a2 = a2; v.d1 = d1; v.d2 = d2; v.p1 = p1; v.p2 = p2; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [4:0] ra,
                         input logic [4:0] a1, input logic [4:0] a2);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_byte_en = be;
        rsv_en = re; rsv_addr = ra; rd_addr_1 = a1; rd_addr_2 = a2;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // rst we wa wd be re ra a1 a2 | d1 d2 p1 p2 cnt (cnt = value before this edge)
        add(1, 1, 4,  32'h12,       4'hF, 0, 0, 4, 4,  32'h0,        32'h0,        0, 0, 0);
        add(0, 1, 4,  32'h12,       4'hF, 0, 0, 4, 0,  32'h12,       32'h0,        0, 0, 0);
        add(0, 1, 20, 32'h2,        4'hF, 0, 0, 4, 20, 32'h12,       32'h2,        0, 0, 0);
        add(0, 1, 5,  32'hA,        4'hF, 0, 0, 5, 20, 32'hA,        32'h2,        0, 0, 0);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 5, 20, 32'hA,        32'h2,        0, 0, 0);
        add(0, 1, 7,  32'hAABBCCDD, 4'hF, 0, 0, 7, 4,  32'hAABBCCDD, 32'h12,       0, 0, 0);
        add(0, 1, 7,  32'h11223344, 4'h5, 0, 0, 7, 7,  32'hAA22CC44, 32'hAA22CC44, 0, 0, 0);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 7, 0,  32'hAA22CC44, 32'h0,        0, 0, 0);
        add(0, 0, 0,  32'h0,        4'h0, 1, 3, 3, 7,  32'h0,        32'hAA22CC44, 0, 0, 0);
        add(0, 1, 3,  32'h33,       4'hF, 0, 0, 3, 3,  32'h33,       32'h33,       0, 0, 1);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 3, 3,  32'h33,       32'h33,       0, 0, 0);
        add(0, 1, 9,  32'h99,       4'hF, 1, 9, 9, 9,  32'h99,       32'h99,       0, 0, 0);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 9, 3,  32'h99,       32'h33,       1, 0, 1);
        add(0, 1, 0,  32'hFFFFFFFF, 4'hF, 1, 0, 0, 0,  32'h0,        32'h0,        0, 0, 1);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 0, 9,  32'h0,        32'h99,       0, 1, 1);
        add(0, 1, 9,  32'hFFFFFFFF, 4'h0, 0, 0, 9, 9,  32'h99,       32'h99,       0, 0, 1);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 9, 9,  32'h99,       32'h99,       0, 0, 0);
        add(0, 0, 0,  32'h0,        4'h0, 1, 1, 1, 2,  32'h0,        32'h0,        0, 0, 0);
        add(0, 0, 0,  32'h0,        4'h0, 1, 2, 1, 2,  32'h0,        32'h0,        1, 0, 1);
        add(0, 0, 0,  32'h0,        4'h0, 1, 3, 1, 2,  32'h0,        32'h0,        1, 1, 2);
        add(0, 0, 0,  32'h0,        4'h0, 1, 4, 4, 3,  32'h12,       32'h33,       0, 1, 3);
        add(0, 1, 1,  32'h11,       4'hF, 1, 1, 1, 4,  32'h11,       32'h12,       1, 1, 4);
        add(1, 1, 2,  32'h55,       4'hF, 0, 0, 2, 4,  32'h0,        32'h0,        0, 0, 4);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 2, 1,  32'h0,        32'h0,        0, 0, 0);
        add(0, 1, 2,  32'h55,       4'hF, 0, 0, 2, 4,  32'h55,       32'h0,        0, 0, 0);
        add(0, 0, 0,  32'h0,        4'h0, 0, 0, 2, 2,  32'h55,       32'h55,       0, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].we, vq[i].wa, vq[i].wd, vq[i].be, vq[i].re, vq[i].ra,
                  vq[i].a1, vq[i].a2);
            #1;
            chk("rd_data_1", i, rd_data_1, vq[i].d1);
            chk("rd_data_2", i, rd_data_2, vq[i].d2);
            chk("rd_pend_1", i, 32'(rd_pend_1), 32'(vq[i].p1));
            chk("rd_pend_2", i, 32'(rd_pend_2), 32'(vq[i].p2));
            chk("pend_count", i, 32'(pend_count), 32'(vq[i].cnt));
            @(negedge clk);
        end

        // Reserve every non-zero register: count tops out at 31 with x0 hardwired.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), 5'd0, 5'd0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd31, 5'd0);
        #1;
        chk("full_count", 0, 32'(pend_count), 32'd31);
        chk("full_pend_31", 0, 32'(rd_pend_1), 32'd1);
        chk("full_pend_x0", 0, 32'(rd_pend_2), 32'd0);

        // Zero-byte-enable writes retire every reservation without touching data.
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'hDEADBEEF, 4'h0, 1'b0, 5'd0, 5'd2, 5'd0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd2, 5'd31);
        #1;
        chk("drain_count", 0, 32'(pend_count), 32'd0);
        chk("drain_data_2", 0, rd_data_1, 32'h55);
        chk("drain_pend_31", 0, 32'(rd_pend_2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
